// File: rtl/if_stage.sv
// Instruction fetch stage: owns the fetch PC, runs a single-outstanding imem
// handshake, and feeds the IF/ID register through a one-entry skid buffer.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus_4_o,
  output logic        valid_o
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT_SLOT, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus_4_q, pc_plus_4_d;
  logic        valid_q, valid_d;

  logic [31:0] redirect_aligned;
  logic [31:0] fetch_pc_inc;
  logic        slot_free;

  assign redirect_aligned = redirect_pc_i & 32'hFFFF_FFFC;
  assign fetch_pc_inc     = fetch_pc_q + 32'd4;
  assign slot_free        = !valid_q || !stall_i;

  assign imem_req_o    = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr_o   = fetch_pc_q;
  assign instruction_o = instr_q;
  assign pc_o          = pc_q;
  assign pc_plus_4_o   = pc_plus_4_q;
  assign valid_o       = valid_q;

  // The skid holds live data only while in WAIT_SLOT, so leaving that state
  // on a redirect is what clears it.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    pc_plus_4_d  = pc_plus_4_q;
    valid_d      = valid_q && stall_i;

    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (redirect_i) begin
          valid_d = 1'b0;
          if (imem_ack_i) begin
            fetch_pc_d = redirect_aligned;
          end else begin
            pending_pc_d = redirect_aligned;
            state_d      = DRAIN;
          end
        end else if (imem_ack_i) begin
          fetch_pc_d = fetch_pc_inc;
          if (slot_free) begin
            instr_d     = imem_rdata_i;
            pc_d        = fetch_pc_q;
            pc_plus_4_d = fetch_pc_inc;
            valid_d     = 1'b1;
          end else begin
            skid_instr_d = imem_rdata_i;
            skid_pc_d    = fetch_pc_q;
            state_d      = WAIT_SLOT;
          end
        end
      end
      WAIT_SLOT: begin
        if (redirect_i) begin
          valid_d    = 1'b0;
          fetch_pc_d = redirect_aligned;
          state_d    = FETCH;
        end else if (!stall_i) begin
          instr_d     = skid_instr_q;
          pc_d        = skid_pc_q;
          pc_plus_4_d = skid_pc_q + 32'd4;
          valid_d     = 1'b1;
          state_d     = FETCH;
        end
      end
      DRAIN: begin
        // The old response is thrown away; the newest target wins.
        if (redirect_i) begin
          valid_d      = 1'b0;
          pending_pc_d = redirect_aligned;
          if (imem_ack_i) begin
            fetch_pc_d = redirect_aligned;
            state_d    = FETCH;
          end
        end else if (imem_ack_i) begin
          fetch_pc_d = pending_pc_q;
          state_d    = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= 32'd0;
      skid_instr_q <= 32'd0;
      skid_pc_q    <= 32'd0;
      instr_q      <= 32'd0;
      pc_q         <= 32'd0;
      pc_plus_4_q  <= 32'd0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      pc_plus_4_q  <= pc_plus_4_d;
      valid_q      <= valid_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus a random run, checked against a
// program-order stream model and handshake/hold/flush rules.
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pc_plus_4;
  logic        valid;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_ack_i(imem_ack), .imem_rdata_i(imem_rdata), .instruction_o(instruction),
    .pc_o(pc), .pc_plus_4_o(pc_plus_4), .valid_o(valid)
  );

  always #5 clk = ~clk;

  int          ncmp = 0;
  int          nerr = 0;
  int          lat = 0;
  int          wcnt = 0;
  int          ncons = 0;
  bit          rand_lat = 0;
  bit          force_ack = 0;
  bit          last_ack = 0;
  logic [31:0] exp_pc = RESET_PC;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F96 ^ (a << 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive the memory, score the ID-side view, advance, check rules.
  task automatic cycle();
    logic p_req, p_ack, p_valid, p_stall, p_redir;
    logic [31:0] p_addr, p_pc, p_instr;
    imem_ack   = force_ack || (imem_req && (wcnt >= lat));
    imem_rdata = memf(imem_addr);
    #1;
    p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
    p_valid = valid; p_pc = pc; p_instr = instruction;
    p_stall = stall; p_redir = redirect;
    if (valid && !stall && !redirect) begin
      chk("seq_pc", pc, exp_pc);
      chk("instr", instruction, memf(pc));
      chk("pc_plus_4", pc_plus_4, pc + 32'd4);
      exp_pc = pc + 32'd4;
      ncons++;
    end
    if (redirect) exp_pc = redirect_pc & 32'hFFFF_FFFC;
    @(posedge clk);
    #1;
    last_ack = p_req && p_ack;
    if (last_ack) begin
      wcnt = 0;
      if (rand_lat) lat = $urandom_range(0, 3);
    end else if (p_req) begin
      wcnt++;
    end
    if (p_redir) begin
      chk("flush_valid", valid, 1'b0);
    end else if (p_valid && p_stall) begin
      chk("hold_valid", valid, 1'b1);
      chk("hold_pc", pc, p_pc);
      chk("hold_instr", instruction, p_instr);
    end
    if (p_req && !p_ack) begin
      chk("req_stable", imem_req, 1'b1);
      chk("addr_stable", imem_addr, p_addr);
    end
  endtask

  task automatic run_to_ack(input int maxc);
    int k;
    k = 0;
    do begin
      cycle();
      k++;
    end while (!last_ack && k < maxc);
    chk("ack_timeout", last_ack, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt, acnt;
    logic [31:0] p0, old_addr;

    // Reset values, then first request in cycle 2 with zero-wait memory.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_pc4", pc_plus_4, 32'd0);
    chk("rst_instr", instruction, 32'd0);
    rst = 1'b0;
    chk("req_c1", imem_req, 1'b0);
    cycle();
    chk("req_c2", imem_req, 1'b1);
    chk("addr_c2", imem_addr, RESET_PC);
    cycle();
    chk("c3_valid", valid, 1'b1);
    chk("c3_pc", pc, RESET_PC);
    chk("c3_pc4", pc_plus_4, RESET_PC + 32'd4);
    cycle();
    chk("c4_pc", pc, RESET_PC + 32'd4);
    cycle();
    chk("c5_pc", pc, RESET_PC + 32'd8);
    chk("c5_valid", valid, 1'b1);

    // 3-cycle memory: one valid cycle per fetched instruction.
    lat = 2;
    run_to_ack(20);
    vcnt = 0; acnt = 0;
    for (int i = 0; i < 9; i++) begin
      if (valid) vcnt++;
      cycle();
      if (last_ack) acnt++;
    end
    chk("lat3_valid_cycles", vcnt, 3);
    chk("lat3_acks", acnt, 3);

    // Four stall cycles with zero-wait memory: one word skidded, req low.
    lat = 0;
    repeat (3) cycle();
    chk("pre_stall_valid", valid, 1'b1);
    p0 = pc;
    stall = 1'b1;
    acnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) chk("req_wait_slot", imem_req, 1'b0);
      cycle();
      if (last_ack) acnt++;
    end
    chk("skid_acks", acnt, 1);
    stall = 1'b0;
    chk("req_release", imem_req, 1'b0);
    cycle();
    chk("skid_out_pc", pc, p0 + 32'd4);
    chk("skid_out_valid", valid, 1'b1);
    cycle();
    chk("after_skid_pc", pc, p0 + 32'd8);

    // Redirect coinciding with an ack.
    redirect = 1'b1; redirect_pc = 32'h0040_0100;
    cycle();
    redirect = 1'b0;
    chk("redir_ack_addr", imem_addr, 32'h0040_0100);
    cycle();
    chk("redir_ack_valid", valid, 1'b1);
    chk("redir_ack_pc", pc, 32'h0040_0100);

    // Redirect while a 3-cycle fetch is outstanding, then a double redirect.
    lat = 2;
    run_to_ack(20);
    old_addr = imem_addr;
    redirect = 1'b1; redirect_pc = 32'h0040_0200;
    cycle();
    redirect = 1'b0;
    chk("drain_addr1", imem_addr, old_addr);
    cycle();
    chk("drain_addr2", imem_addr, old_addr);
    cycle();
    chk("drain_ack", last_ack, 1'b1);
    chk("drain_next_addr", imem_addr, 32'h0040_0200);
    chk("drain_valid", valid, 1'b0);
    run_to_ack(20);
    chk("drain_tgt_pc", pc, 32'h0040_0200);
    redirect = 1'b1; redirect_pc = 32'h0040_0280;
    cycle();
    redirect_pc = 32'h0040_0300;
    cycle();
    redirect = 1'b0;
    cycle();
    chk("drain2_ack", last_ack, 1'b1);
    chk("drain2_addr", imem_addr, 32'h0040_0300);

    // Unaligned target near the top of the address space wraps to 0.
    lat = 0;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    cycle();
    redirect = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    cycle();
    chk("wrap_valid", valid, 1'b1);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus_4, 32'd0);
    chk("wrap_next_addr", imem_addr, 32'd0);
    cycle();
    chk("wrap_pc0", pc, 32'd0);

    // Random stall, latency and redirects against the stream model.
    rand_lat = 1;
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(0, 9) < 3);
      redirect = ($urandom_range(0, 49) == 0);
      redirect_pc = $urandom;
      cycle();
    end
    rand_lat = 0; stall = 1'b0; redirect = 1'b0;
    chk("random_progress", (ncons > 500), 1'b1);

    // Asynchronous reset mid-request; a late ack in IDLE is ignored.
    lat = 3;
    run_to_ack(20);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req", imem_req, 1'b0);
    chk("arst_valid", valid, 1'b0);
    chk("arst_pc", pc, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    lat = 0; wcnt = 0; exp_pc = RESET_PC;
    force_ack = 1;
    chk("idle_req", imem_req, 1'b0);
    cycle();
    force_ack = 0;
    chk("post_rst_req", imem_req, 1'b1);
    chk("post_rst_addr", imem_addr, RESET_PC);
    chk("post_rst_valid", valid, 1'b0);
    cycle();
    chk("post_rst_pc", pc, RESET_PC);
    chk("post_rst_instr", instruction, memf(RESET_PC));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction fetch stage of the cqu_mips five-stage pipeline, sitting directly upstream of the ID stage.
- Owns the fetch PC and drives a single-outstanding-request instruction-memory handshake.
- Holds the IF/ID output register (instruction, pc, pc_plus_4, valid) that ID consumes.
- Handles ID back-pressure through a one-entry skid buffer, and handles branch/jump redirects, discarding any in-flight fetch.

Parameters:
- RESET_PC, 32'hBFC00000, first fetch address after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- stall  input  1  ID cannot accept; output register must hold
- redirect  input  1  branch/jump taken; flush and refetch
- redirect_pc  input  32  target address; bits [1:0] ignored, treated as 0
- imem_req  output  1  fetch request valid
- imem_addr  output  32  fetch address; word aligned
- imem_ack  input  1  response valid; completes the current request
- imem_rdata  input  32  instruction word; valid when imem_ack=1
- instruction  output  32  IF/ID instruction
- pc  output  32  address of instruction
- pc_plus_4  output  32  pc+4, registered with pc
- valid  output  1  instruction/pc/pc_plus_4 hold a live instruction

Behaviour:
- Reset: instruction=0, pc=0, pc_plus_4=0, valid=0, fetch_pc=RESET_PC, skid empty, state IDLE, imem_req=0.
- imem_req and imem_addr are combinational from the state.
- imem_req=1 only in FETCH and DRAIN.
- imem_addr = fetch_pc in FETCH, and the old fetch_pc in DRAIN.
- Handshake: once imem_req=1, imem_req and imem_addr stay stable until the cycle imem_ack=1. At most one request is outstanding. An imem_ack while imem_req=0 is ignored.
- Slot free: valid=0 or stall=0.
- IDLE: next cycle goes to FETCH unconditionally. The first request is therefore visible in the 2nd cycle after rst deasserts.
- FETCH, imem_ack=1, redirect=0, slot free:
  - Load instruction=imem_rdata, pc=fetch_pc, pc_plus_4=fetch_pc+4, valid=1.
  - fetch_pc+=4; stay in FETCH. With zero-wait memory this gives one instruction per cycle.
- FETCH, imem_ack=1, redirect=0, slot busy (valid=1 and stall=1):
  - Capture {imem_rdata, fetch_pc} into skid; fetch_pc+=4.
  - Go to WAIT_SLOT.
- FETCH, imem_ack=0, redirect=0: wait; if the slot is free, valid<=0 (previous instruction consumed).
- WAIT_SLOT: imem_req=0. When stall=0, move skid into the output register (valid=1) and go to FETCH.
- Redirect has priority over stall, ack and the skid in every state:
  - valid<=0 and the skid is cleared.
  - FETCH with imem_ack=1: the response is discarded; fetch_pc<=redirect_pc; stay in FETCH. The next cycle requests the new address.
  - FETCH with imem_ack=0: pending_pc<=redirect_pc; go to DRAIN. The old request stays asserted.
  - WAIT_SLOT: fetch_pc<=redirect_pc; go to FETCH.
  - DRAIN: pending_pc is overwritten by the newest redirect_pc.
- DRAIN: on imem_ack, discard imem_rdata, set fetch_pc<=pending_pc, and go to FETCH.
- ID-side consumption: whenever stall=0 and no new instruction loads that cycle, valid<=0.
- Arithmetic: all PC adds are 32-bit modulo 2^32; 32'hFFFFFFFC+4 wraps to 32'h0. pc_plus_4 is always (pc+4) mod 2^32.
- Asynchronous reset mid-request immediately drops imem_req. Any late imem_ack after reset, while in IDLE, is ignored.
- stall while valid=0 has no effect; the slot is free.

Test Plan:
- Reset, zero-wait memory (imem_ack=1 whenever imem_req=1) -> imem_req first high in cycle 2 at 32'hBFC00000; valid rises the next cycle with pc=BFC00000, pc_plus_4=BFC00004; then pc=...04, ...08 on consecutive cycles.
- 3-cycle memory latency -> imem_addr stable for all 3 cycles; valid high only one cycle per instruction (stall=0); pc steps by 4 per fetch.
- stall=1 for 4 cycles with zero-wait memory -> outputs frozen; exactly one word skidded; imem_req low in WAIT_SLOT. After stall drops: skid word presented, then the next sequential pc, with no instruction lost or duplicated.
- redirect to 32'h00400100 with imem_ack asserted the same cycle -> valid=0 next cycle; that response is never output; next imem_addr=00400100.
- redirect to 32'h00400200 while a 3-cycle fetch is outstanding -> imem_addr unchanged until ack; that response discarded; next request addresses 00400200. A second redirect to 00400300 during DRAIN makes the next request 00400300.
- redirect_pc=32'hFFFFFFFE -> fetch at FFFFFFFC, pc_plus_4=0, next fetch address 0. Assert rst mid-request -> imem_req=0 and valid=0 immediately.
